// File: rtl/vpu_pkg.sv
// Shared definitions for the vector ALU: operation encodings, controller
// state type and the dot-product accumulator sizing rule.
package vpu_pkg;

  typedef enum logic [1:0] {
    MODE_VADD = 2'b00,
    MODE_VDOT = 2'b01,
    MODE_SMUL = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Wide enough to sum vlen full-precision products without wrapping.
  function automatic int acc_width(input int elem_w, input int vlen);
    return 2 * elem_w + $clog2(vlen);
  endfunction

endpackage

// File: rtl/vector_lane.sv
// One element of the vector datapath: signed add, signed multiply and the
// per-element overflow check. Purely combinational.
module vector_lane
  import vpu_pkg::*;
#(
  parameter int ELEM_W = 16
) (
  input  mode_e                 mode_i,
  input  logic [ELEM_W-1:0]     a_i,
  input  logic [ELEM_W-1:0]     b_i,
  input  logic [ELEM_W-1:0]     s_i,
  output logic [ELEM_W-1:0]     res_o,
  output logic [2*ELEM_W-1:0]   prod_o,
  output logic                  ovf_o
);

  logic [ELEM_W:0]     sum;
  logic [ELEM_W-1:0]   mul_x;
  logic [2*ELEM_W-1:0] prod;
  logic [ELEM_W:0]     prod_hi;

  // Sign-extend by one bit so the carry out exposes signed overflow.
  assign sum   = {a_i[ELEM_W-1], a_i} + {b_i[ELEM_W-1], b_i};
  // SMUL scales B by the scalar; VDOT multiplies A by B.
  assign mul_x = (mode_i == MODE_SMUL) ? s_i : a_i;
  // Operands sign-extended to full width, so the low 2*ELEM_W bits of the
  // product are the exact signed product.
  assign prod    = {{ELEM_W{mul_x[ELEM_W-1]}}, mul_x} * {{ELEM_W{b_i[ELEM_W-1]}}, b_i};
  assign prod_hi = prod[2*ELEM_W-1:ELEM_W-1];
  assign prod_o  = prod;

  // Select the element result and flag values outside the signed range.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    case (mode_i)
      MODE_VADD: begin
        res_o = sum[ELEM_W-1:0];
        ovf_o = sum[ELEM_W] ^ sum[ELEM_W-1];
      end
      MODE_SMUL: begin
        res_o = prod[ELEM_W-1:0];
        ovf_o = !((&prod_hi) || !(|prod_hi));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_alu.sv
// Multi-cycle vector ALU: VADD, VDOT and SMUL over VLEN elements, LANES
// elements per beat. Results and flags are published only on completion.
module vector_alu
  import vpu_pkg::*;
#(
  parameter int ELEM_W = 16,
  parameter int VLEN   = 16,
  parameter int LANES  = 4
) (
  input  logic                   Clk1,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic [1:0]             Mode,
  input  logic [VLEN*ELEM_W-1:0] A,
  input  logic [VLEN*ELEM_W-1:0] B,
  input  logic [ELEM_W-1:0]      S,
  output logic                   Busy,
  output logic                   Done,
  output logic [VLEN*ELEM_W-1:0] VecOut,
  output logic [ELEM_W-1:0]      ScalOut,
  output logic                   V,
  output logic                   Err
);

  localparam int VW      = VLEN * ELEM_W;
  localparam int NBEATS  = VLEN / LANES;
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ACC_W   = acc_width(ELEM_W, VLEN);
  localparam int SLICE_W = LANES * ELEM_W;

  if (VLEN % LANES != 0) begin : g_bad_lanes
    $error("vector_alu: VLEN must be a multiple of LANES");
  end

  state_e              state_q;
  mode_e               mode_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [VW-1:0]       a_q, b_q, res_q, vec_q;
  logic [ELEM_W-1:0]   s_q, scal_q;
  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q, v_q, err_q, done_q, busy_q;

  logic [ELEM_W-1:0]   lane_a   [LANES];
  logic [ELEM_W-1:0]   lane_b   [LANES];
  logic [ELEM_W-1:0]   lane_res [LANES];
  logic [2*ELEM_W-1:0] lane_prod[LANES];
  logic [LANES-1:0]    lane_ovf;
  logic [SLICE_W-1:0]  beat_res;
  logic [ACC_W-1:0]    beat_dot;
  logic [ACC_W-ELEM_W:0] acc_hi;
  logic                acc_ovf;

  // Pick the elements belonging to the current beat.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = a_q[(int'(beat_q) * LANES + l) * ELEM_W +: ELEM_W];
      lane_b[l] = b_q[(int'(beat_q) * LANES + l) * ELEM_W +: ELEM_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_lane #(.ELEM_W(ELEM_W)) u_lane (
      .mode_i (mode_q),
      .a_i    (lane_a[g]),
      .b_i    (lane_b[g]),
      .s_i    (s_q),
      .res_o  (lane_res[g]),
      .prod_o (lane_prod[g]),
      .ovf_o  (lane_ovf[g])
    );
  end

  // Gather lane results and reduce the lane products for this beat.
  always_comb begin
    beat_res = '0;
    beat_dot = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_res[l*ELEM_W +: ELEM_W] = lane_res[l];
      beat_dot = beat_dot + {{(ACC_W-2*ELEM_W){lane_prod[l][2*ELEM_W-1]}}, lane_prod[l]};
    end
  end

  // The final sum fits ELEM_W signed bits only if its upper bits are all copies of the sign.
  assign acc_hi  = acc_q[ACC_W-1:ELEM_W-1];
  assign acc_ovf = !((&acc_hi) || !(|acc_hi));

  // Controller and every registered output; results publish on DONE exit.
  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  // NOTE: operand and result registers are reset too; they are few and Reset must zero the outputs.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_VADD;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      vec_q   <= '0;
      scal_q  <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            mode_q  <= mode_e'(Mode);
            a_q     <= A;
            b_q     <= B;
            s_q     <= S;
            beat_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (mode_e'(Mode) == MODE_RSVD) ? ST_DONE : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (Abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            res_q[int'(beat_q) * SLICE_W +: SLICE_W] <= beat_res;
            if (mode_q == MODE_VDOT) acc_q <= acc_q + beat_dot;
            ovf_q  <= ovf_q | (|lane_ovf);
            beat_q <= beat_q + 1'b1;
            if (beat_q == BEAT_W'(NBEATS - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          case (mode_q)
            MODE_RSVD: begin
              err_q <= 1'b1;
              v_q   <= 1'b0;
            end
            MODE_VDOT: begin
              err_q  <= 1'b0;
              v_q    <= acc_ovf;
              scal_q <= acc_q[ELEM_W-1:0];
            end
            default: begin
              err_q <= 1'b0;
              v_q   <= ovf_q;
              vec_q <= res_q;
            end
          endcase
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign VecOut  = vec_q;
  assign ScalOut = scal_q;
  assign V       = v_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_vector_alu.sv
// Scoreboard bench for vector_alu: stimulus pushes expected results from an
// arithmetic reference model; a monitor pops and compares on every Done.
module tb_vector_alu;

  localparam int W      = 16;
  localparam int VLEN   = 16;
  localparam int LANES  = 4;
  localparam int VW     = VLEN * W;
  localparam int NBEATS = VLEN / LANES;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  typedef struct {
    logic [VW-1:0] vec;
    logic [W-1:0]  scal;
    logic          v;
    logic          err;
  } exp_t;

  logic          Clk1, Reset, Start, Abort;
  logic [1:0]    Mode;
  logic [VW-1:0] A, B;
  logic [W-1:0]  S;
  logic          Busy, Done, V, Err;
  logic [VW-1:0] VecOut;
  logic [W-1:0]  ScalOut;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t m;        // model of the currently published outputs
  exp_t mon_e;

  vector_alu #(.ELEM_W(W), .VLEN(VLEN), .LANES(LANES)) dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .Start   (Start),
    .Abort   (Abort),
    .Mode    (Mode),
    .A       (A),
    .B       (B),
    .S       (S),
    .Busy    (Busy),
    .Done    (Done),
    .VecOut  (VecOut),
    .ScalOut (ScalOut),
    .V       (V),
    .Err     (Err)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: element-wise integer arithmetic on signed values.
  function automatic exp_t model(input logic [1:0] mode, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [W-1:0] s, input exp_t prev);
    exp_t   r;
    longint ea, eb, es, t, dot;
    r     = prev;
    r.v   = 1'b0;
    r.err = 1'b0;
    dot   = 0;
    es    = longint'($signed(s));
    for (int i = 0; i < VLEN; i++) begin
      ea = longint'($signed(a[i*W +: W]));
      eb = longint'($signed(b[i*W +: W]));
      case (mode)
        2'b00: begin
          t = ea + eb;
          r.vec[i*W +: W] = t[W-1:0];
          if (t > MAXV || t < MINV) r.v = 1'b1;
        end
        2'b10: begin
          t = es * eb;
          r.vec[i*W +: W] = t[W-1:0];
          if (t > MAXV || t < MINV) r.v = 1'b1;
        end
        2'b01: dot = dot + ea * eb;
        default: ;
      endcase
    end
    if (mode == 2'b01) begin
      r.scal = dot[W-1:0];
      r.v    = (dot > MAXV || dot < MINV);
    end
    if (mode == 2'b11) r.err = 1'b1;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VLEN; i++)
      v[i*W +: W] = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'(int'($urandom_range(0, 8)) - 4);
    return v;
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clk1) begin
    if (Reset && Done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done act=1 exp=0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("vecout", VecOut, mon_e.vec);
        check("scalout", VW'(ScalOut), VW'(mon_e.scal));
        check("v_flag", VW'(V), VW'(mon_e.v));
        check("err_flag", VW'(Err), VW'(mon_e.err));
      end
    end
  end

  // Issue one operation and follow it to completion (or to its abort).
  task automatic run_op(input logic [1:0] mode, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [W-1:0] s, input int abort_n, input bit noise, input bit abort_with_start);
    bit aborting;
    bit got;
    int lat;
    aborting = (mode != 2'b11) && (abort_n >= 0) && (abort_n < NBEATS);
    @(negedge Clk1);
    Mode  = mode;
    A     = a;
    B     = b;
    S     = s;
    Start = 1'b1;
    Abort = abort_with_start;
    @(negedge Clk1);
    Start = 1'b0;
    Abort = 1'b0;
    if (!aborting) begin
      m = model(mode, a, b, s, m);
      exp_q.push_back(m);
    end
    check("busy_after_start", VW'(Busy), VW'(1));
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      if (noise) begin
        A    = rand_vec();
        B    = rand_vec();
        S    = W'($urandom);
        Mode = 2'($urandom);
      end
      Start = noise && (lat == 2);
      Abort = (lat == abort_n);
      @(negedge Clk1);
      lat++;
      if (Done) got = 1'b1;
      if (aborting && lat == abort_n + 1) check("busy_after_abort", VW'(Busy), VW'(0));
    end
    Start = 1'b0;
    Abort = 1'b0;
    if (aborting) check("no_done_after_abort", VW'(got), VW'(0));
    else check("done_latency", VW'(lat), VW'((mode == 2'b11) ? 1 : NBEATS + 1));
  endtask

  initial begin
    logic [VW-1:0] va, vb;
    Reset = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    Mode  = 2'b00;
    A     = '0;
    B     = '0;
    S     = '0;
    m     = '{vec: '0, scal: '0, v: 1'b0, err: 1'b0};
    #12;
    check("rst_busy", VW'(Busy), VW'(0));
    check("rst_done", VW'(Done), VW'(0));
    check("rst_vec", VecOut, '0);
    check("rst_scal", VW'(ScalOut), VW'(0));
    check("rst_v", VW'(V), VW'(0));
    check("rst_err", VW'(Err), VW'(0));
    @(negedge Clk1);
    Reset = 1'b1;

    // VADD: A=1, B=i -> i+1
    for (int i = 0; i < VLEN; i++) begin
      va[i*W +: W] = W'(1);
      vb[i*W +: W] = W'(i);
    end
    run_op(2'b00, va, vb, '0, -1, 1'b0, 1'b0);

    // VADD overflow in a single element
    va = '0;
    vb = '0;
    va[3*W +: W] = W'(16'h7FFF);
    vb[3*W +: W] = W'(1);
    run_op(2'b00, va, vb, '0, -1, 1'b0, 1'b0);

    // VDOT in range, then VDOT that overflows the element width
    for (int i = 0; i < VLEN; i++) begin
      va[i*W +: W] = W'(2);
      vb[i*W +: W] = W'(3);
    end
    run_op(2'b01, va, vb, '0, -1, 1'b0, 1'b0);
    for (int i = 0; i < VLEN; i++) begin
      va[i*W +: W] = W'(16'h0100);
      vb[i*W +: W] = W'(16'h0100);
    end
    run_op(2'b01, va, vb, '0, -1, 1'b0, 1'b0);

    // SMUL by -1 with inputs scrambled and a stray Start while busy
    for (int i = 0; i < VLEN; i++) vb[i*W +: W] = W'(i);
    run_op(2'b10, rand_vec(), vb, W'(16'hFFFF), -1, 1'b1, 1'b0);

    // Reserved mode, then VADD aborted in its second EXEC cycle
    run_op(2'b11, rand_vec(), rand_vec(), W'($urandom), -1, 1'b0, 1'b0);
    run_op(2'b00, rand_vec(), rand_vec(), '0, 1, 1'b0, 1'b0);
    check("abort_hold_vec", VecOut, m.vec);
    check("abort_hold_err", VW'(Err), VW'(m.err));

    // Abort alone in IDLE does nothing
    @(negedge Clk1);
    Abort = 1'b1;
    @(negedge Clk1);
    Abort = 1'b0;
    check("idle_abort_busy", VW'(Busy), VW'(0));

    // Reset on the third EXEC cycle discards the operation
    @(negedge Clk1);
    Mode  = 2'b00;
    A     = rand_vec();
    B     = rand_vec();
    Start = 1'b1;
    @(negedge Clk1);
    Start = 1'b0;
    repeat (2) @(negedge Clk1);
    Reset = 1'b0;
    #1;
    check("midrst_busy", VW'(Busy), VW'(0));
    check("midrst_done", VW'(Done), VW'(0));
    check("midrst_vec", VecOut, '0);
    check("midrst_scal", VW'(ScalOut), VW'(0));
    check("midrst_v", VW'(V), VW'(0));
    check("midrst_err", VW'(Err), VW'(0));
    m = '{vec: '0, scal: '0, v: 1'b0, err: 1'b0};
    @(negedge Clk1);
    Reset = 1'b1;
    repeat (8) @(negedge Clk1);
    run_op(2'b00, rand_vec(), rand_vec(), '0, -1, 1'b0, 1'b0);

    // Randomized back-to-back operations
    for (int k = 0; k < 24; k++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NBEATS)) : -1;
      run_op(2'($urandom), rand_vec(), rand_vec(), W'($urandom), ab,
             (ab < 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge Clk1);
    check("queue_drained", VW'(exp_q.size()), VW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vector_alu.md
VECTOR_ALU -- requirements
Module: vector_alu

Interface
REQ-001 Parameter ELEM_W, default 16: element width in bits, signed two's complement.
REQ-002 Parameter VLEN, default 16: elements per vector operand.
REQ-003 Parameter LANES, default 4: elements processed per cycle; VLEN mod LANES SHALL be 0, otherwise elaboration fails.
REQ-004 Clk1  input  1  the only clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  request a new operation; sampled only in IDLE.
REQ-007 Abort  input  1  synchronous cancel of an operation in progress.
REQ-008 Mode  input  2  operation select: 00 VADD, 01 VDOT, 10 SMUL, 11 reserved.
REQ-009 A  input  VLEN*ELEM_W  vector operand A; element i is A[i*ELEM_W +: ELEM_W].
REQ-010 B  input  VLEN*ELEM_W  vector operand B, same packing as A.
REQ-011 S  input  ELEM_W  scalar operand for SMUL.
REQ-012 Busy  output  1  high in EXEC and DONE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 VecOut  output  VLEN*ELEM_W  vector result of VADD/SMUL.
REQ-015 ScalOut  output  ELEM_W  scalar result of VDOT.
REQ-016 V  output  1  overflow flag for the last completed operation.
REQ-017 Err  output  1  reserved-mode flag for the last completed operation.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-019 FSM transitions: IDLE->EXEC on Start with Mode!=11; IDLE->DONE on Start with Mode==11; EXEC->DONE after the last beat; DONE->IDLE unconditionally.
REQ-020 On accepting Start, A, B, S and Mode SHALL be latched and all later input changes ignored; beat counter, accumulator and overflow flag are cleared.
REQ-021 EXEC SHALL process elements beat*LANES .. beat*LANES+LANES-1 each cycle, for VLEN/LANES beats.
REQ-022 Latency: Start sampled at edge 0 -> Done high for exactly the cycle after edge VLEN/LANES+1 (5 cycles with defaults); Start may be reasserted in the cycle following Done.
REQ-023 Start while Busy SHALL be ignored without effect.
REQ-024 VADD: VecOut element = (A+B) mod 2^ELEM_W; V set if any element sum leaves the signed ELEM_W range.
REQ-025 SMUL: VecOut element = low ELEM_W bits of S*B; V set if any full product leaves the signed ELEM_W range.
REQ-026 VDOT: accumulator width 2*ELEM_W+clog2(VLEN), sign-extended products, no intermediate overflow; ScalOut = low ELEM_W bits of the final sum; V set if the final sum leaves the signed ELEM_W range.
REQ-027 Reserved mode: no arithmetic, Err=1, V=0, VecOut/ScalOut hold previous values; Done pulses in the cycle after acceptance.
REQ-028 VecOut, ScalOut, V and Err SHALL update only at the DONE transition and hold until the next Done; VDOT leaves VecOut unchanged, VADD/SMUL leave ScalOut unchanged.
REQ-029 Abort in EXEC SHALL return to IDLE next edge with no Done and outputs unchanged; Abort in IDLE or DONE has no effect; Abort and Start together in IDLE: Start wins.
REQ-030 Overflow flag SHALL be sticky across beats within one operation.

Reset
REQ-031 Reset low SHALL immediately force IDLE, clear the beat counter and accumulator, and drive Busy=0, Done=0, V=0, Err=0, VecOut=0 and ScalOut=0.
REQ-032 Reset mid-operation SHALL discard the operation, with no Done afterwards.

Structure
REQ-033 Package vpu_pkg SHALL hold the Mode encodings, the FSM state typedef and the accumulator width function.
REQ-034 Sub-module vector_lane SHALL hold the single-element datapath (add, multiply, product for VDOT, overflow detect); it is instantiated LANES times.

Verification
REQ-035 Defaults; VADD, A elements all 0x0001, B elements i -> VecOut elements i+1, V=0, Done 5 cycles after Start.
REQ-036 VADD with A[3]=0x7FFF, B[3]=0x0001, all others 0 -> VecOut[3]=0x8000, V=1.
REQ-037 VDOT, A all 0x0002, B all 0x0003 -> ScalOut=0x0060, V=0; repeat with A and B all 0x0100 -> ScalOut=0x0000, V=1.
REQ-038 SMUL with S=0xFFFF (-1), B element i=i -> element i=-i, V=0; Start pulsed again on the third Busy cycle is ignored.
REQ-039 Mode=11 -> Done 1 cycle after Start, Err=1, outputs unchanged; Abort on the second EXEC cycle of VADD -> no Done, Busy low next cycle.
REQ-040 Reset driven low on the third EXEC cycle -> all outputs 0 immediately, no Done; a fresh VADD then completes normally.
